wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the single GPR write port of the write-back stage between two producers: the ALU result path and the memory-load result path. Each producer uses a valid/ready handshake. The block picks one winner per cycle and drives a registered write (enable, address, data) into the GPR file. Memory loads win by default; an anti-starvation counter guarantees the ALU path eventually gets through.

Parameters:
STARVE_LIMIT, 4, consecutive cycles the ALU request may lose before it is forced to win (range 1..15)
DATA_W, 32, width of write data
ADDR_W, 5, width of GPR index (32 registers)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
alu_valid  input  1  ALU result request
alu_ready  output  1  ALU request accepted this cycle
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load result request
mem_ready  output  1  load request accepted this cycle
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
gpr_we  output  1  GPR write enable (registered)
gpr_waddr  output  ADDR_W  GPR write index (registered)
gpr_wdata  output  DATA_W  GPR write data (registered)
conflict_cnt  output  16  saturating count of cycles in which both requests were valid

Behaviour:
- Reset: on a posedge with rst=1, all of the following go to 0: gpr_we, gpr_waddr, gpr_wdata, conflict_cnt, and the internal starve counter. While rst=1, alu_ready=0 and mem_ready=0, so no transfer occurs.
- Grant (combinational, rst=0):
  - Only mem_valid high: grant mem.
  - Only alu_valid high: grant alu.
  - Both high: grant alu if starve==STARVE_LIMIT, else grant mem.
  - Neither high: no grant.
- alu_ready and mem_ready equal the corresponding grant. At most one is high per cycle. Ready never depends on ready.
- Transfer: a transfer happens when valid && ready. A requester must hold valid, rd and data stable until its transfer; the arbiter does not buffer them.
- Output register (1-cycle latency):
  - Cycle after a transfer: gpr_we=1 if the winning rd!=0; gpr_waddr and gpr_wdata equal the winner's rd and data.
  - rd==0: the request is still accepted (ready=1) but gpr_we=0. x0 is never written. waddr/wdata still update.
  - No transfer: gpr_we=0 and waddr/wdata hold their previous values.
- Starve counter (width 4, posedge):
  - Reset to 0 when alu is granted or alu_valid=0.
  - Otherwise increments, saturating at STARVE_LIMIT.
- conflict_cnt: increments when alu_valid && mem_valid; saturates at 16'hFFFF with no wrap.
- Same rd from both requesters in the same cycle: each write is issued in a separate cycle in grant order. The last granted write is what remains in the GPR.
- rst asserted mid-arbitration: any pending grant is dropped and nothing is written on the following cycle. Requesters retain their valid and re-arbitrate after reset.
- Throughput: one write per cycle with back-to-back transfers. No bubbles are inserted.

Test Plan:
- Reset: drive rst=1 for 2 cycles with both valid high -> both ready=0; gpr_we=0, gpr_waddr=0, gpr_wdata=0 and conflict_cnt=0 at the following posedge.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=32'h12 for one cycle -> alu_ready=1 that cycle; next cycle gpr_we=1, gpr_waddr=5, gpr_wdata=32'h12; the cycle after, gpr_we=0.
- x0 suppression: mem_valid=1, mem_rd=0, mem_data=32'hDEAD -> mem_ready=1; next cycle gpr_we=0, gpr_waddr=0, gpr_wdata=32'hDEAD.
- Starvation with STARVE_LIMIT=4 and both valid held continuously, mem_rd=3, alu_rd=7:
  - mem granted for 4 cycles, alu granted on the 5th cycle.
  - Pattern repeats: 4 mem, 1 alu.
  - conflict_cnt increments every cycle.
- Same rd conflict: both valid in one cycle with rd=9, mem_data=32'hA, alu_data=32'hB; alu drops valid after its grant -> writes (9,32'hA) then (9,32'hB) on consecutive cycles.
- Saturation: preload by holding both valid for 65,540 cycles -> conflict_cnt stops at 16'hFFFF and does not wrap to 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single GPR write port between the ALU result
// path and the memory-load result path. Loads win by default; a starve
// counter forces the ALU through after STARVE_LIMIT consecutive losses.
// The GPR write (enable, index, data) is registered: one cycle of latency.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              gpr_we,
  output logic [ADDR_W-1:0] gpr_waddr,
  output logic [DATA_W-1:0] gpr_wdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve;
  logic       grant_alu;
  logic       grant_mem;
  logic       both_valid;

  assign both_valid = alu_valid && mem_valid;

  // Grant selection: loads win ties unless the ALU has starved long enough.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst) begin
      if (both_valid) begin
        if (starve == STARVE_MAX) begin
          grant_alu = 1'b1;
        end else begin
          grant_mem = 1'b1;
        end
      end else if (alu_valid) begin
        grant_alu = 1'b1;
      end else if (mem_valid) begin
        grant_mem = 1'b1;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Starve counter: counts consecutive cycles an ALU request loses, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (grant_alu || !alu_valid) begin
      starve <= '0;
    end else if (starve != STARVE_MAX) begin
      starve <= starve + 4'd1;
    end
  end

  // Registered GPR write; x0 is accepted but never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_we    <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      gpr_we <= 1'b0;
      if (grant_alu) begin
        gpr_we    <= (alu_rd != '0);
        gpr_waddr <= alu_rd;
        gpr_wdata <= alu_data;
      end else if (grant_mem) begin
        gpr_we    <= (mem_rd != '0);
        gpr_waddr <= mem_rd;
        gpr_wdata <= mem_data;
      end
    end
  end

  // Saturating count of cycles with both producers requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (both_valid && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors with hand-computed expectations for
// reset, single writes, x0 suppression, starvation, same-rd ordering,
// mid-arbitration reset and conflict counter saturation.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [15:0] conflict_cnt;

  int unsigned n_chk;
  int unsigned n_bad;

  wb_port_arbiter #(
    .STARVE_LIMIT(4),
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd(mem_rd),
    .mem_data(mem_data),
    .gpr_we(gpr_we),
    .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;

    // Reset with both requests held.
    rst       = 1'b1;
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    alu_rd    = 5'd7;
    mem_rd    = 5'd3;
    alu_data  = 32'h77;
    mem_data  = 32'h33;
    #1;
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    tick();
    chk("rst_alu_ready2", 64'(alu_ready), 64'd0);
    chk("rst_mem_ready2", 64'(mem_ready), 64'd0);
    chk("rst_we", 64'(gpr_we), 64'd0);
    chk("rst_waddr", 64'(gpr_waddr), 64'd0);
    chk("rst_wdata", 64'(gpr_wdata), 64'd0);
    chk("rst_conflict", 64'(conflict_cnt), 64'd0);

    // Single ALU write.
    rst       = 1'b0;
    mem_valid = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h12;
    #1;
    chk("alu_ready", 64'(alu_ready), 64'd1);
    chk("alu_only_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    alu_valid = 1'b0;
    chk("alu_we", 64'(gpr_we), 64'd1);
    chk("alu_waddr", 64'(gpr_waddr), 64'd5);
    chk("alu_wdata", 64'(gpr_wdata), 64'h12);
    tick();
    chk("idle_we", 64'(gpr_we), 64'd0);
    chk("idle_waddr_hold", 64'(gpr_waddr), 64'd5);
    chk("idle_wdata_hold", 64'(gpr_wdata), 64'h12);

    // x0 load: accepted, not written.
    mem_valid = 1'b1;
    mem_rd    = 5'd0;
    mem_data  = 32'hDEAD;
    #1;
    chk("x0_mem_ready", 64'(mem_ready), 64'd1);
    tick();
    mem_valid = 1'b0;
    chk("x0_we", 64'(gpr_we), 64'd0);
    chk("x0_waddr", 64'(gpr_waddr), 64'd0);
    chk("x0_wdata", 64'(gpr_wdata), 64'hDEAD);

    // Starvation: 4 mem grants then 1 alu grant, repeating.
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    alu_rd    = 5'd7;
    mem_rd    = 5'd3;
    alu_data  = 32'h77;
    mem_data  = 32'h33;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("starve_alu_ready", 64'(alu_ready), ((k % 5) == 4) ? 64'd1 : 64'd0);
      chk("starve_mem_ready", 64'(mem_ready), ((k % 5) == 4) ? 64'd0 : 64'd1);
      tick();
      chk("starve_we", 64'(gpr_we), 64'd1);
      chk("starve_waddr", 64'(gpr_waddr), ((k % 5) == 4) ? 64'd7 : 64'd3);
      chk("starve_wdata", 64'(gpr_wdata), ((k % 5) == 4) ? 64'h77 : 64'h33);
      chk("starve_conflict", 64'(conflict_cnt), 64'(k + 1));
    end

    // Same rd from both: mem first, then alu.
    alu_rd   = 5'd9;
    mem_rd   = 5'd9;
    alu_data = 32'hB;
    mem_data = 32'hA;
    #1;
    chk("same_mem_ready", 64'(mem_ready), 64'd1);
    tick();
    mem_valid = 1'b0;
    chk("same_first_we", 64'(gpr_we), 64'd1);
    chk("same_first_waddr", 64'(gpr_waddr), 64'd9);
    chk("same_first_wdata", 64'(gpr_wdata), 64'hA);
    chk("same_conflict", 64'(conflict_cnt), 64'd11);
    #1;
    chk("same_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    chk("same_second_we", 64'(gpr_we), 64'd1);
    chk("same_second_waddr", 64'(gpr_waddr), 64'd9);
    chk("same_second_wdata", 64'(gpr_wdata), 64'hB);

    // Reset mid-arbitration: grant dropped, re-arbitrate afterwards.
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    alu_rd    = 5'd7;
    mem_rd    = 5'd3;
    alu_data  = 32'h77;
    mem_data  = 32'h33;
    rst       = 1'b1;
    #1;
    chk("midrst_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    chk("midrst_we", 64'(gpr_we), 64'd0);
    chk("midrst_conflict", 64'(conflict_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("rearb_mem_ready", 64'(mem_ready), 64'd1);
    tick();
    chk("rearb_we", 64'(gpr_we), 64'd1);
    chk("rearb_waddr", 64'(gpr_waddr), 64'd3);

    // Saturation: clear, then hold both valid for 65540 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_start", 64'(conflict_cnt), 64'd0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
    tick();
    chk("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
